sha256_block_mr: RTL and testbench
==================================

# sha256_block_mr

Parametrised multi-round SHA-256 compression engine, successor to the single-round block hasher. It performs 64 rounds on one 512-bit block at ROUNDS_PER_CYCLE rounds per clock and adds the result into the chaining hash. It adds a chain mode for multi-block messages and a one-cycle completion pulse. It sits under the bitcoin_hash top level as the per-block hashing engine, and can be instantiated several times for parallel nonces.

## Interface
- ROUNDS_PER_CYCLE, 1, rounds per compute cycle; legal values 1, 2, 4, 8; any other value is an elaboration error.
- NUM_CYCLES, 64/ROUNDS_PER_CYCLE, derived localparam; not overridable.
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while ready=1.
- chain  in  1  sampled with start. 0: load h from h_init and a..h from alpha_init. 1: keep current hash and load a..h from current hash.
- h_init[8]  in  8x32  initial chaining hash, index 0 = H0.
- alpha_init[8]  in  8x32  initial working variables a..h.
- memory_block  in  512  message block; word t = memory_block[t*32 +: 32]. Must stay stable from the start edge until done_pulse.
- hash[8]  out  8x32  chaining hash registers H0..H7.
- alpha[8]  out  8x32  working-variable registers a..h.
- ready  out  1  high in IDLE.
- done_pulse  out  1  one-cycle pulse on the first IDLE cycle after a finalise.

## Operation
- States:
  - IDLE: ready=1.
  - COMPUTE: rnd counter 0..NUM_CYCLES-1.
  - FINAL: add working variables into the hash.
  - Any illegal encoding goes to IDLE.
- IDLE & start: capture hash and a..h per chain; rnd<=0; go to COMPUTE.
- IDLE & !start: hold all registers.
- COMPUTE: apply ROUNDS_PER_CYCLE chained rounds combinationally for rounds t = rnd*R .. rnd*R+R-1.
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t]
  - T2 = Σ0(a) + Maj(a,b,c)
  - Update: a' = T1+T2, e' = d+T1, the rest shift.
  - All additions are mod 2^32; carries are discarded.
  - On rnd = NUM_CYCLES-1, go to FINAL.
- Message schedule uses a 16-word sliding window register, not a 64-entry array.
  - t<16: W[t] = block word t.
  - t≥16: W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16].
  - σ0 = ROTR7^ROTR18^SHR3; σ1 = ROTR17^ROTR19^SHR10.
  - Each cycle the window shifts by R words. Words produced within the same cycle feed later rounds of that cycle combinationally.
  - Window is loaded from memory_block on the start edge.
- FINAL: Hi <= Hi + alpha_i for i = 0..7; done_pulse<=1; go to IDLE. alpha holds the final round values.
- start while ready=0 is ignored; it is not queued.
- Reset, at any time including mid-COMPUTE: state=IDLE, hash=0, alpha=0, rnd=0, window=0, done_pulse=0, ready=1. No partial result survives reset.
- chain=1 with no prior block uses the current hash contents (0 after reset). This is legal and deterministic.

## Timing
- Edge E0: start accepted (ready=1).
- Edges E1..E_NUM_CYCLES: compute. E_NUM_CYCLES+1: FINAL.
- Latency, start edge to done_pulse-high cycle: NUM_CYCLES+1 edges. R=1: 65; R=2: 33; R=4: 17; R=8: 9.
- ready falls the cycle after E0 and rises together with done_pulse.
- start asserted in the same cycle done_pulse is high is accepted. Back-to-back throughput is one block per NUM_CYCLES+2 cycles.
- hash and alpha are stable and valid while ready=1, until the next accepted start.
- done_pulse is exactly one cycle wide, even if start is held high.

## Test plan
- "abc", R=1, chain=0:
  - Stimulus: h_init = alpha_init = 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19; word0=61626380, words1-14=0, word15=00000018.
  - Response: done_pulse exactly 65 cycles after start; hash = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Same "abc" vector at R=2, 4, 8 -> identical hash; done_pulse at 33, 17, 9 cycles.
- Two-block chaining, message "abcdbcdecdefghijklmnopqrstuvwxyz"-style 448-bit test string "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - Stimulus: block 1 with chain=0, then block 2 (padding, length 000001c0) with chain=1.
  - Response: hash = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- start pulsed at cycle 10 of a run, and start held high throughout -> no restart. Result still "abc" hash. Runs restart back-to-back, and each done_pulse is one cycle.
- reset_n low at COMPUTE cycle 30 -> asynchronously hash=0, alpha=0, ready=1, done_pulse=0. A subsequent fresh "abc" run gives the correct hash.
- chain=1 immediately after reset with the "abc" block -> hash equals the compression of the all-zero state plus zero. Checked against the reference model; no X on outputs.

Source files
------------

// File: rtl/sha256_block_mr.sv
// rtl/sha256_block_mr.sv - multi-round SHA-256 compression engine with chain mode
// Runs 64 rounds on one 512-bit block, ROUNDS_PER_CYCLE per clock, then adds into the chaining hash.
module sha256_block_mr #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         chain,
  input  logic [31:0]  h_init [8],
  input  logic [31:0]  alpha_init [8],
  input  logic [511:0] memory_block,
  output logic [31:0]  hash [8],
  output logic [31:0]  alpha [8],
  output logic         ready,
  output logic         done_pulse
);
  localparam int R          = ROUNDS_PER_CYCLE;
  localparam int NUM_CYCLES = 64 / R;
  localparam int LOG2R      = $clog2(R);
  localparam logic [5:0] LAST_RND = 6'(NUM_CYCLES - 1);

  generate
    if (R != 1 && R != 2 && R != 4 && R != 8) begin : g_bad_rounds
      $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end
  endgenerate

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_FINAL   = 2'd2
  } state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  rnd_q, rnd_d;
  logic        done_q, done_d;
  logic [31:0] hash_q  [8];
  logic [31:0] hash_d  [8];
  logic [31:0] alpha_q [8];
  logic [31:0] alpha_d [8];
  logic [31:0] win_q   [16];
  logic [31:0] win_d   [16];

  logic [5:0]  t_base;
  logic [31:0] ext [16+R];
  logic [31:0] v   [R+1][8];
  logic [31:0] t1, t2;

  assign t_base = rnd_q << LOG2R;

  // ext[j] is W[t_base+j]; words past the window are generated so later rounds in the same cycle can use them
  always_comb begin
    t1 = '0;
    t2 = '0;
    for (int i = 0; i < 16; i++) ext[i] = win_q[i];
    for (int k = 0; k < R; k++)
      ext[16+k] = ssig1(ext[14+k]) + ext[9+k] + ssig0(ext[1+k]) + ext[k];
    for (int i = 0; i < 8; i++) v[0][i] = alpha_q[i];
    for (int j = 0; j < R; j++) begin
      t1 = v[j][7] + bsig1(v[j][4]) + ((v[j][4] & v[j][5]) ^ (~v[j][4] & v[j][6]))
         + K[t_base + 6'(j)] + ext[j];
      t2 = bsig0(v[j][0]) + ((v[j][0] & v[j][1]) ^ (v[j][0] & v[j][2]) ^ (v[j][1] & v[j][2]));
      v[j+1][0] = t1 + t2;
      v[j+1][1] = v[j][0];
      v[j+1][2] = v[j][1];
      v[j+1][3] = v[j][2];
      v[j+1][4] = v[j][3] + t1;
      v[j+1][5] = v[j][4];
      v[j+1][6] = v[j][5];
      v[j+1][7] = v[j][6];
    end
  end

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;
    hash_d  = hash_q;
    alpha_d = alpha_q;
    win_d   = win_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int i = 0; i < 8; i++) begin
            hash_d[i]  = chain ? hash_q[i] : h_init[i];
            alpha_d[i] = chain ? hash_q[i] : alpha_init[i];
          end
          for (int t = 0; t < 16; t++) win_d[t] = memory_block[t*32 +: 32];
          rnd_d   = '0;
          state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        for (int i = 0; i < 8; i++) alpha_d[i] = v[R][i];
        for (int i = 0; i < 16; i++) win_d[i] = ext[R+i];
        rnd_d = rnd_q + 6'd1;
        if (rnd_q == LAST_RND) state_d = S_FINAL;
      end
      S_FINAL: begin
        for (int i = 0; i < 8; i++) hash_d[i] = hash_q[i] + alpha_q[i];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rnd_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        hash_q[i]  <= '0;
        alpha_q[i] <= '0;
      end
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
      hash_q  <= hash_d;
      alpha_q <= alpha_d;
      win_q   <= win_d;
    end
  end

  assign hash       = hash_q;
  assign alpha      = alpha_q;
  assign ready      = (state_q == S_IDLE);
  assign done_pulse = done_q;

endmodule

// File: tb/tb_sha256_block_mr.sv
// tb/tb_sha256_block_mr.sv - directed-vector bench for sha256_block_mr at R = 1, 2, 4, 8
module tb_sha256_block_mr;

  localparam logic [255:0] IV  = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] TWO = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic         chain;
  logic [31:0]  h_init [8];
  logic [31:0]  alpha_init [8];
  logic [511:0] blk;
  logic [31:0]  wds [16];

  logic [255:0] hv [4];
  logic [255:0] av [4];
  logic         rdy [4];
  logic         dn [4];

  int n_total = 0;
  int n_bad   = 0;
  int lat [4];
  int npulse [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic [31:0] hash_g [8];
    logic [31:0] alpha_g [8];
    logic        rdy_g, dn_g;
    sha256_block_mr #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .chain        (chain),
      .h_init       (h_init),
      .alpha_init   (alpha_init),
      .memory_block (blk),
      .hash         (hash_g),
      .alpha        (alpha_g),
      .ready        (rdy_g),
      .done_pulse   (dn_g)
    );
    assign hv[g]  = {hash_g[0], hash_g[1], hash_g[2], hash_g[3], hash_g[4], hash_g[5], hash_g[6], hash_g[7]};
    assign av[g]  = {alpha_g[0], alpha_g[1], alpha_g[2], alpha_g[3], alpha_g[4], alpha_g[5], alpha_g[6], alpha_g[7]};
    assign rdy[g] = rdy_g;
    assign dn[g]  = dn_g;
  end

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Straightforward reference: full 64-word schedule, then 64 rounds, then feed-forward.
  function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [255:0] ain,
                                                input logic [511:0] b);
    logic [31:0]  w [64];
    logic [31:0]  s [8];
    logic [31:0]  x1, x2;
    logic [255:0] res;
    for (int t = 0; t < 16; t++) w[t] = b[t*32 +: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int i = 0; i < 8; i++) s[i] = ain[(7-i)*32 +: 32];
    for (int t = 0; t < 64; t++) begin
      x1 = s[7] + (rr(s[4], 6) ^ rr(s[4], 11) ^ rr(s[4], 25)) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + KT[t] + w[t];
      x2 = (rr(s[0], 2) ^ rr(s[0], 13) ^ rr(s[0], 22)) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      for (int i = 7; i > 0; i--) s[i] = s[i-1];
      s[4] = s[4] + x1;
      s[0] = x1 + x2;
    end
    for (int i = 0; i < 8; i++) res[(7-i)*32 +: 32] = hin[(7-i)*32 +: 32] + s[i];
    return res;
  endfunction

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_blk();
    for (int t = 0; t < 16; t++) blk[t*32 +: 32] = wds[t];
  endtask

  task automatic set_abc();
    for (int t = 0; t < 16; t++) wds[t] = 32'h0;
    wds[0]  = 32'h61626380;
    wds[15] = 32'h00000018;
    load_blk();
  endtask

  // One start pulse to every instance, then 80 observed cycles recording latency and pulse count.
  task automatic run_all(input logic ch);
    chain = ch;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int g = 0; g < 4; g++) begin
      check_eq($sformatf("ready_low_after_start_r%0d", 1 << g), 256'(rdy[g]), 256'd0);
      lat[g]    = 0;
      npulse[g] = 0;
    end
    for (int n = 1; n <= 80; n++) begin
      tick();
      for (int g = 0; g < 4; g++) begin
        if (dn[g]) begin
          npulse[g]++;
          if (lat[g] == 0) lat[g] = n;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, run_len, max_run, lat0;
    int ppos [2];
    logic [255:0] exp_zero;

    reset_n = 1'b0;
    start   = 1'b0;
    chain   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      h_init[i]     = IV[(7-i)*32 +: 32];
      alpha_init[i] = IV[(7-i)*32 +: 32];
    end
    set_abc();
    repeat (2) tick();
    for (int g = 0; g < 4; g++) begin
      check_eq($sformatf("reset_hash_r%0d", 1 << g), hv[g], 256'd0);
      check_eq($sformatf("reset_ready_r%0d", 1 << g), 256'(rdy[g]), 256'd1);
      check_eq($sformatf("reset_done_r%0d", 1 << g), 256'(dn[g]), 256'd0);
    end
    reset_n = 1'b1;
    tick();

    // "abc" single block at every rounds-per-cycle setting
    run_all(1'b0);
    for (int g = 0; g < 4; g++) begin
      check_eq($sformatf("abc_latency_r%0d", 1 << g), 256'(lat[g]), 256'(64 / (1 << g) + 1));
      check_eq($sformatf("abc_hash_r%0d", 1 << g), hv[g], ABC);
      check_eq($sformatf("abc_pulses_r%0d", 1 << g), 256'(npulse[g]), 256'd1);
    end

    // two-block message using chain mode for the second block
    wds = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
            32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
            32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    load_blk();
    run_all(1'b0);
    for (int t = 0; t < 16; t++) wds[t] = 32'h0;
    wds[15] = 32'h000001c0;
    load_blk();
    run_all(1'b1);
    for (int g = 0; g < 4; g++)
      check_eq($sformatf("two_block_hash_r%0d", 1 << g), hv[g], TWO);

    // start pulsed mid-run must not restart or queue (R=1 instance)
    set_abc();
    chain = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat0 = 0;
    for (int n = 1; n <= 80; n++) begin
      start = (n == 10);
      tick();
      if (dn[0] && lat0 == 0) lat0 = n;
    end
    start = 1'b0;
    check_eq("midrun_start_latency_r1", 256'(lat0), 256'd65);
    check_eq("midrun_start_hash_r1", hv[0], ABC);
    check_eq("midrun_start_not_queued_r1", 256'(rdy[0]), 256'd1);

    // start held high: back-to-back runs, each pulse one cycle wide
    start   = 1'b1;
    pulses  = 0;
    run_len = 0;
    max_run = 0;
    ppos[0] = 0;
    ppos[1] = 0;
    for (int n = 1; n <= 140; n++) begin
      tick();
      if (dn[0]) begin
        if (pulses < 2) ppos[pulses] = n;
        pulses++;
        run_len++;
        check_eq("held_start_hash_r1", hv[0], ABC);
      end else begin
        run_len = 0;
      end
      if (run_len > max_run) max_run = run_len;
    end
    start = 1'b0;
    check_eq("held_start_pulses_r1", 256'(pulses), 256'd2);
    check_eq("held_start_pulse_width_r1", 256'(max_run), 256'd1);
    check_eq("held_start_first_pulse_r1", 256'(ppos[0]), 256'd66);
    check_eq("held_start_period_r1", 256'(ppos[1] - ppos[0]), 256'd66);
    repeat (80) tick();

    // asynchronous reset during COMPUTE cycle 30
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    #2;
    reset_n = 1'b0;
    #1;
    for (int g = 0; g < 4; g++) begin
      check_eq($sformatf("async_reset_hash_r%0d", 1 << g), hv[g], 256'd0);
      check_eq($sformatf("async_reset_alpha_r%0d", 1 << g), av[g], 256'd0);
      check_eq($sformatf("async_reset_ready_r%0d", 1 << g), 256'(rdy[g]), 256'd1);
      check_eq($sformatf("async_reset_done_r%0d", 1 << g), 256'(dn[g]), 256'd0);
    end
    #3;
    reset_n = 1'b1;
    tick();
    run_all(1'b0);
    check_eq("after_reset_abc_hash_r1", hv[0], ABC);
    check_eq("after_reset_abc_latency_r1", 256'(lat[0]), 256'd65);

    // chain=1 straight out of reset compresses the all-zero state
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    tick();
    set_abc();
    exp_zero = ref_compress(256'd0, 256'd0, blk);
    run_all(1'b1);
    for (int g = 0; g < 4; g++) begin
      check_eq($sformatf("chain_from_reset_hash_r%0d", 1 << g), hv[g], exp_zero);
      check_eq($sformatf("chain_from_reset_xfree_r%0d", 1 << g), 256'($isunknown({hv[g], av[g]})), 256'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
